// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx pacing stage: bit index limit, FSM encoding
// and the baud divider derivation.
package uart_tx_sched_pkg;

    localparam logic [3:0] BIT_LAST = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_sched_sync_fifo.sv
// Small synchronous FIFO without fall-through; the head is read combinationally and
// a write while full is dropped with a one-cycle ovf pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A push and pop together leave the count unchanged while both pointers move.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Pacing stage for uart_tx: buffers bytes, issues the per-frame load strobe and the
// per-bit timing strobes for back-to-back 8N1 frames.
import uart_tx_sched_pkg::*;

module uart_tx_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       tx_flag,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic       tx_bit_flag,
    output logic [3:0] tx_bit_cnt,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       ovf,
    output logic       busy
);

    localparam int           BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
    localparam int           BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [3:0]    bit_next;
    logic [7:0]    po_data_next;
    logic          po_flag_next;
    logic          bit_flag_next;
    logic          rd_en;
    logic          wrap;
    logic [7:0]    fifo_rd_data;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .sclk   (sclk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .ovf    (ovf)
    );

    assign rd_en = (state == ST_IDLE) && !fifo_empty && !tx_flag;
    assign wrap  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (rd_en) state_next = ST_SEND;
            ST_SEND: if (wrap && tx_bit_cnt == BIT_LAST) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The load strobe and the bit-0 strobe are launched together so uart_tx sees both on one edge.
    always_comb begin
        baud_next     = baud_cnt;
        bit_next      = tx_bit_cnt;
        po_data_next  = po_data;
        po_flag_next  = 1'b0;
        bit_flag_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_en) begin
                    po_data_next  = fifo_rd_data;
                    po_flag_next  = 1'b1;
                    bit_flag_next = 1'b1;
                    bit_next      = 4'd0;
                    baud_next     = '0;
                end
            end
            ST_SEND: begin
                if (wrap) begin
                    baud_next = '0;
                    if (tx_bit_cnt == BIT_LAST) begin
                        bit_next = 4'd0;
                    end else begin
                        bit_next      = tx_bit_cnt + 4'd1;
                        bit_flag_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            baud_cnt    <= '0;
            tx_bit_cnt  <= 4'd0;
            po_data     <= 8'd0;
            po_flag     <= 1'b0;
            tx_bit_flag <= 1'b0;
            busy        <= 1'b0;
        end else begin
            baud_cnt    <= baud_next;
            tx_bit_cnt  <= bit_next;
            po_data     <= po_data_next;
            po_flag     <= po_flag_next;
            tx_bit_flag <= bit_flag_next;
            busy        <= (state_next == ST_SEND);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with BAUD_DIV=10: expected bytes are queued as
// they are written and compared against the frames the DUT launches.
module tb_uart_tx_sched;

    logic       sclk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_flag;
    logic       po_flag;
    logic [7:0] po_data;
    logic       tx_bit_flag;
    logic [3:0] tx_bit_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ovf;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_seen = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc[$];

    uart_tx_sched #(
        .CLK_FREQ(1000),
        .BAUD    (100),
        .DEPTH   (16)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_flag    (tx_flag),
        .po_flag    (po_flag),
        .po_data    (po_data),
        .tx_bit_flag(tx_bit_flag),
        .tx_bit_cnt (tx_bit_cnt),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc++;

    // Every launched frame is captured with its cycle number for the tests to score.
    always @(negedge sclk) begin
        if (po_flag) begin
            obs_q.push_back(po_data);
            obs_cyc.push_back(cyc);
        end
        if (ovf) ovf_seen++;
    end

    task automatic tick();
        @(negedge sclk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (obs_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int i;
        i = 0;
        while ((busy || !fifo_empty) && i < budget) begin
            tick();
            i++;
        end
        ok = !busy && fifo_empty;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        tx_flag = 1'b0;
        repeat (3) tick();
        total++;
        if ({po_flag, tx_bit_flag, ovf, busy, fifo_full, fifo_empty} !== 6'b000001) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected 000001",
                     {po_flag, tx_bit_flag, ovf, busy, fifo_full, fifo_empty});
        end
        total++;
        if (po_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_po_data: got %h expected 00", po_data);
        end
        total++;
        if (tx_bit_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_bit_cnt: got %0d expected 0", tx_bit_cnt);
        end
        rst = 1'b0;
        pulses = 0;
        repeat (200) begin
            tick();
            if (po_flag || tx_bit_flag || ovf) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL reset_quiet: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] line_exp;
        logic       line;
        bit         ok;
        line_exp = 10'b11_0100_1010;
        clear_sb();
        tick();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        total++;
        if (po_flag !== 1'b0 || fifo_empty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_early: got po_flag=%b empty=%b expected 0 0", po_flag, fifo_empty);
        end
        tick();
        total++;
        if ({po_flag, tx_bit_flag} !== 2'b11 || tx_bit_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL single_launch: got po=%b bit=%b cnt=%0d expected 1 1 0",
                     po_flag, tx_bit_flag, tx_bit_cnt);
        end
        total++;
        if (obs_q.size() != 1 || po_data !== exp_q[0]) begin
            bad++;
            $display("[TB] FAIL single_data: got %h expected %h", po_data, exp_q[0]);
        end
        exp_q.delete();
        obs_q.delete();
        for (int k = 1; k <= 9; k++) begin
            repeat (9) tick();
            total++;
            if (tx_bit_flag !== 1'b0 || tx_bit_cnt !== 4'(k - 1)) begin
                bad++;
                $display("[TB] FAIL single_gap%0d: got flag=%b cnt=%0d expected 0 %0d",
                         k, tx_bit_flag, tx_bit_cnt, k - 1);
            end
            tick();
            total++;
            if (tx_bit_flag !== 1'b1 || tx_bit_cnt !== 4'(k)) begin
                bad++;
                $display("[TB] FAIL single_bit%0d: got flag=%b cnt=%0d expected 1 %0d",
                         k, tx_bit_flag, tx_bit_cnt, k);
            end
            line = (tx_bit_cnt == 4'd9) ? 1'b1 : po_data[tx_bit_cnt - 4'd1];
            total++;
            if (line !== line_exp[k]) begin
                bad++;
                $display("[TB] FAIL single_line%0d: got %b expected %b", k, line, line_exp[k]);
            end
        end
        repeat (9) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_stop_busy: got %b expected 1", busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || tx_bit_cnt !== 4'd0 || obs_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL single_end: got busy=%b cnt=%0d extra=%0d expected 0 0 0",
                     busy, tx_bit_cnt, obs_q.size());
        end
        wait_idle(50, ok);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[3];
        int         ovf0;
        int         prev;
        bit         ok;
        vals = '{8'h00, 8'hFF, 8'h3C};
        clear_sb();
        ovf0 = ovf_seen;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_en = 1'b1;
            wr_data = vals[i];
            exp_q.push_back(vals[i]);
        end
        tick();
        wr_en = 1'b0;
        wait_obs(3, 400, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL b2b_timeout: got %0d frames expected 3", obs_q.size());
        end
        prev = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got;
            logic [7:0] want;
            int         c;
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            c    = obs_cyc.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL b2b_data: got %h expected %h", got, want);
            end
            if (prev != 0) begin
                total++;
                if (c - prev != 101) begin
                    bad++;
                    $display("[TB] FAIL b2b_spacing: got %0d expected 101", c - prev);
                end
            end
            prev = c;
        end
        total++;
        if (ovf_seen !== ovf0) begin
            bad++;
            $display("[TB] FAIL b2b_ovf: got %0d pulses expected 0", ovf_seen - ovf0);
        end
        wait_idle(200, ok);
    endtask

    task automatic test_overflow();
        int ovf0;
        int n;
        bit ok;
        clear_sb();
        ovf0 = ovf_seen;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 16) begin
                total++;
                if (fifo_full !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ovf_not_full: got %b expected 0", fifo_full);
                end
            end
            if (i == 17) begin
                total++;
                if (fifo_full !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL ovf_full: got %b expected 1", fifo_full);
                end
            end
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
            if (i < 17) exp_q.push_back(8'(8'h40 + i));
        end
        tick();
        wr_en = 1'b0;
        total++;
        if (ovf !== 1'b1 || fifo_full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_pulse: got ovf=%b full=%b expected 1 1", ovf, fifo_full);
        end
        wait_obs(17, 1800, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL ovf_timeout: got %0d frames expected 17", obs_q.size());
        end
        n = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] got;
            logic [7:0] want;
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            n++;
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL ovf_data%0d: got %h expected %h", n, got, want);
            end
        end
        repeat (150) tick();
        total++;
        if (obs_q.size() != 0 || fifo_empty !== 1'b1 || ovf_seen - ovf0 != 1) begin
            bad++;
            $display("[TB] FAIL ovf_tail: got extra=%0d empty=%b ovf=%0d expected 0 1 1",
                     obs_q.size(), fifo_empty, ovf_seen - ovf0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int i;
        int pulses;
        bit ok;
        clear_sb();
        for (int k = 0; k < 4; k++) begin
            tick();
            wr_en = 1'b1;
            wr_data = 8'(8'hC0 + k);
        end
        exp_q.push_back(8'hC0);
        tick();
        wr_en = 1'b0;
        wait_obs(1, 20, ok);
        total++;
        if (!ok || obs_q[0] !== exp_q[0]) begin
            bad++;
            $display("[TB] FAIL midrst_first: got %0d frames expected 1 with data c0", obs_q.size());
        end
        clear_sb();
        i = 0;
        while (tx_bit_cnt != 4'd4 && i < 100) begin
            tick();
            i++;
        end
        total++;
        if (tx_bit_cnt !== 4'd4) begin
            bad++;
            $display("[TB] FAIL midrst_reach: got cnt=%0d expected 4", tx_bit_cnt);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (tx_bit_cnt !== 4'd0 || fifo_empty !== 1'b1 || busy !== 1'b0 || po_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midrst_async: got cnt=%0d empty=%b busy=%b data=%h expected 0 1 0 00",
                     tx_bit_cnt, fifo_empty, busy, po_data);
        end
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (300) begin
            tick();
            if (tx_bit_flag) pulses++;
        end
        total++;
        if (obs_q.size() != 0 || pulses != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_after: got frames=%0d bits=%0d busy=%b expected 0 0 0",
                     obs_q.size(), pulses, busy);
        end
    endtask

    task automatic test_stall();
        int  rel;
        int  c0;
        int  c1;
        bit  ok;
        clear_sb();
        tick();
        tx_flag = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            wr_en = 1'b1;
            wr_data = 8'(8'h5A + k);
            exp_q.push_back(8'(8'h5A + k));
        end
        tick();
        wr_en = 1'b0;
        repeat (50) tick();
        total++;
        if (obs_q.size() != 0 || busy !== 1'b0 || fifo_empty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold: got frames=%0d busy=%b empty=%b expected 0 0 0",
                     obs_q.size(), busy, fifo_empty);
        end
        tick();
        tx_flag = 1'b0;
        rel = cyc;
        wait_obs(2, 300, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL stall_timeout: got %0d frames expected 2", obs_q.size());
        end
        if (ok) begin
            c0 = obs_cyc[0];
            c1 = obs_cyc[1];
            total++;
            if (c0 - rel < 1 || c0 - rel > 2) begin
                bad++;
                $display("[TB] FAIL stall_latency: got %0d expected 1..2", c0 - rel);
            end
            total++;
            if (c1 - c0 != 101) begin
                bad++;
                $display("[TB] FAIL stall_spacing: got %0d expected 101", c1 - c0);
            end
            total++;
            if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                bad++;
                $display("[TB] FAIL stall_data: got %h %h expected %h %h",
                         obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
            end
        end
        clear_sb();
        wait_idle(200, ok);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
